// File: rtl/regfile_debug_dumper_if.sv
// Register-file debug port plus TX byte stream bundle for the debug dumper.
// master = the dumper; slave = the register file / transmitter side.
interface regfile_debug_dumper_if #(
  parameter int NUM_BITS  = 32,
  parameter int NUM_REGS  = 32,
  parameter int TAM_DIREC = $clog2(NUM_REGS)
);
  logic                 start;
  logic [TAM_DIREC-1:0] read_direc_debug;
  logic [NUM_BITS-1:0]  data_debug;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, data_debug, tx_ready,
    output read_direc_debug, tx_data, tx_valid, busy, done
  );

  modport slave (
    output start, data_debug, tx_ready,
    input  read_direc_debug, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/regfile_debug_dumper.sv
// Walks every register through the debug read port and streams each value
// MSB byte first over a valid/ready byte interface toward the debug UART.
module regfile_debug_dumper #(
  parameter int NUM_BITS  = 32,
  parameter int NUM_REGS  = 32,
  parameter int TAM_DIREC = $clog2(NUM_REGS)
) (
  input  logic clk,
  input  logic rst,
  regfile_debug_dumper_if.master dbg
);

  localparam int NUM_BYTES = NUM_BITS / 8;
  localparam int BCW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [TAM_DIREC-1:0] LAST_ADDR = TAM_DIREC'(NUM_REGS - 32'sd1);
  localparam logic [TAM_DIREC-1:0] ADDR_ONE  = TAM_DIREC'(1'b1);
  localparam logic [BCW-1:0]       LAST_BYTE = BCW'(NUM_BYTES - 32'sd1);
  localparam logic [BCW-1:0]       BYTE_ONE  = BCW'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [TAM_DIREC-1:0] addr_r;
  logic [BCW-1:0]       byte_cnt_r;
  logic [NUM_BITS-1:0]  shift_r;
  logic                 busy_r;
  logic                 valid_r;
  logic                 done_r;
  logic                 busy_next_s;
  logic                 valid_next_s;
  logic                 done_next_s;
  logic                 accept_s;
  logic                 last_byte_s;
  logic                 last_addr_s;

  // valid_r is exactly "in SEND", so ready only ever reaches next-state logic
  assign accept_s    = valid_r & dbg.tx_ready;
  assign last_byte_s = (byte_cnt_r == LAST_BYTE);
  assign last_addr_s = (addr_r == LAST_ADDR);

  // State register together with the registered state-decoded outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= busy_next_s;
      valid_r <= valid_next_s;
      done_r  <= done_next_s;
    end
  end

  // Next-state logic: start is only honoured from IDLE
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (dbg.start) begin
          state_next_s = ST_READ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ: state_next_s = ST_SEND;
      ST_SEND: begin
        if (!accept_s) begin
          state_next_s = ST_SEND;
        end else if (!last_byte_s) begin
          state_next_s = ST_SEND;
        end else if (!last_addr_s) begin
          state_next_s = ST_READ;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the outputs land registered
  always_comb begin
    busy_next_s  = 1'b0;
    valid_next_s = 1'b0;
    done_next_s  = 1'b0;
    case (state_next_s)
      ST_IDLE: begin
        busy_next_s = 1'b0;
      end
      ST_READ: begin
        busy_next_s = 1'b1;
      end
      ST_SEND: begin
        busy_next_s  = 1'b1;
        valid_next_s = 1'b1;
      end
      ST_DONE: begin
        busy_next_s = 1'b1;
        done_next_s = 1'b1;
      end
      default: begin
        busy_next_s = 1'b0;
      end
    endcase
  end

  // Datapath: address walk, byte counter and MSB-first shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r     <= {TAM_DIREC{1'b0}};
      byte_cnt_r <= {BCW{1'b0}};
      shift_r    <= {NUM_BITS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (dbg.start) begin
            addr_r <= {TAM_DIREC{1'b0}};
          end
        end
        ST_READ: begin
          // register file data settled on the falling edge of this cycle
          shift_r    <= dbg.data_debug;
          byte_cnt_r <= {BCW{1'b0}};
        end
        ST_SEND: begin
          if (accept_s) begin
            if (!last_byte_s) begin
              shift_r    <= shift_r << 4'd8;
              byte_cnt_r <= byte_cnt_r + BYTE_ONE;
            end else if (!last_addr_s) begin
              addr_r <= addr_r + ADDR_ONE;
            end
          end
        end
        ST_DONE: begin
          addr_r  <= {TAM_DIREC{1'b0}};
          shift_r <= {NUM_BITS{1'b0}};
        end
        default: begin
          addr_r <= {TAM_DIREC{1'b0}};
        end
      endcase
    end
  end

  assign dbg.read_direc_debug = addr_r;
  assign dbg.tx_data          = shift_r[NUM_BITS-1 -: 8];
  assign dbg.tx_valid         = valid_r;
  assign dbg.busy             = busy_r;
  assign dbg.done             = done_r;

  regfile_debug_dumper_chk #(
    .NUM_REGS  (NUM_REGS),
    .TAM_DIREC (TAM_DIREC)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (valid_r),
    .tx_ready (dbg.tx_ready),
    .tx_data  (shift_r[NUM_BITS-1 -: 8]),
    .addr     (addr_r),
    .busy     (busy_r),
    .done     (done_r)
  );

endmodule

// Protocol properties of the dumper's outputs.
module regfile_debug_dumper_chk #(
  parameter int NUM_REGS  = 32,
  parameter int TAM_DIREC = $clog2(NUM_REGS)
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 tx_valid,
  input logic                 tx_ready,
  input logic [7:0]           tx_data,
  input logic [TAM_DIREC-1:0] addr,
  input logic                 busy,
  input logic                 done
);
  localparam logic [TAM_DIREC-1:0] LAST_ADDR = TAM_DIREC'(NUM_REGS - 32'sd1);

  a_hold_until_accept: assert property (@(posedge clk) disable iff (rst)
    (tx_valid && !tx_ready) |=> (tx_valid && $stable(tx_data)));

  a_addr_in_range: assert property (@(posedge clk) disable iff (rst)
    addr <= LAST_ADDR);

  a_done_shape: assert property (@(posedge clk) disable iff (rst)
    done |-> (busy && !tx_valid));

  a_valid_implies_busy: assert property (@(posedge clk) disable iff (rst)
    tx_valid |-> busy);
endmodule

// File: tb/tb_regfile_debug_dumper.sv
// Scoreboard bench: stimulus queues expected bytes, negedge monitors pop and compare.
module tb_regfile_debug_dumper;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_a    = 0;
  int acc_b    = 0;

  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];

  logic       prev_valid_a = 1'b0;
  logic       prev_ready_a = 1'b0;
  logic [7:0] prev_data_a  = 8'h00;

  regfile_debug_dumper_if #(.NUM_BITS(32), .NUM_REGS(32)) ifa ();
  regfile_debug_dumper_if #(.NUM_BITS(16), .NUM_REGS(4))  ifb ();

  regfile_debug_dumper #(.NUM_BITS(32), .NUM_REGS(32)) dut_a (
    .clk (clk),
    .rst (rst),
    .dbg (ifa)
  );

  regfile_debug_dumper #(.NUM_BITS(16), .NUM_REGS(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .dbg (ifb)
  );

  always #5 clk = ~clk;

  // Register file models: data follows the address on the falling edge
  always @(negedge clk) begin
    ifa.data_debug <= 32'hDEAD0000 | {27'd0, ifa.read_direc_debug};
    ifb.data_debug <= 16'h1200 | {14'd0, ifb.read_direc_debug};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor A: pop on each handshake, and check hold behaviour while stalled
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_valid_a && !prev_ready_a) begin
        check("hold_valid_a", {31'd0, ifa.tx_valid}, 32'd1);
        check("hold_data_a", {24'd0, ifa.tx_data}, {24'd0, prev_data_a});
      end
      if (ifa.tx_valid && ifa.tx_ready) begin
        if (sb_a.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_byte_a: got %0h expected none at %0t", ifa.tx_data, $time);
        end else begin
          check("byte_a", {24'd0, ifa.tx_data}, {24'd0, sb_a.pop_front()});
        end
        acc_a++;
      end
      prev_valid_a = ifa.tx_valid;
      prev_ready_a = ifa.tx_ready;
      prev_data_a  = ifa.tx_data;
    end else begin
      prev_valid_a = 1'b0;
      prev_ready_a = 1'b0;
    end
  end

  // Monitor B: narrow parameter variant
  always @(negedge clk) begin
    if (!rst && ifb.tx_valid && ifb.tx_ready) begin
      if (sb_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_byte_b: got %0h expected none at %0t", ifb.tx_data, $time);
      end else begin
        check("byte_b", {24'd0, ifb.tx_data}, {24'd0, sb_b.pop_front()});
      end
      acc_b++;
    end
  end

  task automatic push_dump_a();
    for (int r = 0; r < 32; r++) begin
      logic [7:0] lo;
      lo = r[7:0];
      sb_a.push_back(8'hDE);
      sb_a.push_back(8'hAD);
      sb_a.push_back(8'h00);
      sb_a.push_back(lo);
    end
  endtask

  // mode 0: ready high, 1: random 30% ready, 3: start spammed, 4: stall at reg 31
  task automatic run_dump(input int mode, input int exp_cycles);
    int cyc;
    int dones;
    int done_cyc;
    int stall_left;
    int base;
    bit stalled;
    cyc = 0; dones = 0; done_cyc = 0; stall_left = 0; stalled = 1'b0;
    base = acc_a;
    push_dump_a();
    @(posedge clk); #1;
    ifa.start    = 1'b1;
    ifa.tx_ready = (mode == 1) ? ($urandom_range(0, 99) < 30) : 1'b1;
    while (cyc < 3000 && !(dones > 0 && cyc >= done_cyc + 20)) begin
      @(posedge clk);
      cyc++;
      #1;
      ifa.start = (mode == 3 && dones == 0);
      if (mode == 4 && !stalled && ifa.tx_valid && ifa.read_direc_debug == 5'd31) begin
        stalled    = 1'b1;
        stall_left = 50;
      end
      if (mode == 1) begin
        ifa.tx_ready = ($urandom_range(0, 99) < 30);
      end else if (stall_left > 0) begin
        ifa.tx_ready = 1'b0;
        stall_left--;
      end else begin
        ifa.tx_ready = 1'b1;
      end
      @(negedge clk);
      if (mode == 4 && stalled && !ifa.tx_ready) begin
        check("stall_addr", {27'd0, ifa.read_direc_debug}, 32'd31);
        check("stall_data", {24'd0, ifa.tx_data}, 32'hDE);
      end
      if (ifa.done) begin
        dones++;
        done_cyc = cyc;
        check("busy_during_done", {31'd0, ifa.busy}, 32'd1);
        check("valid_during_done", {31'd0, ifa.tx_valid}, 32'd0);
      end
      if (dones > 0 && cyc == done_cyc + 1) begin
        check("busy_after_done", {31'd0, ifa.busy}, 32'd0);
      end
    end
    ifa.start    = 1'b0;
    ifa.tx_ready = 1'b1;
    check("done_count", dones, 32'd1);
    if (exp_cycles > 0) begin
      check("done_latency", done_cyc, exp_cycles);
    end
    check("byte_count", acc_a - base, 32'd128);
    check("sb_a_empty", sb_a.size(), 32'd0);
    check("idle_after_dump", {31'd0, ifa.busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    int base;
    int cyc;
    rst = 1'b1;
    ifa.start = 1'b0; ifa.tx_ready = 1'b0;
    ifb.start = 1'b0; ifb.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, ifa.tx_valid}, 32'd0);
    check("rst_busy", {31'd0, ifa.busy}, 32'd0);
    check("rst_done", {31'd0, ifa.done}, 32'd0);
    check("rst_data", {24'd0, ifa.tx_data}, 32'd0);
    check("rst_addr", {27'd0, ifa.read_direc_debug}, 32'd0);
    check("rst_busy_b", {31'd0, ifb.busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_dump(0, 161);
    run_dump(1, -1);

    // Mid-dump asynchronous reset after 10 accepted bytes
    base = acc_a;
    push_dump_a();
    @(posedge clk); #1;
    ifa.start = 1'b1; ifa.tx_ready = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    guard = 0;
    while ((acc_a - base) < 10 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("reached_10_bytes", acc_a - base, 32'd10);
    @(posedge clk); #1;
    check("pre_reset_addr", {27'd0, ifa.read_direc_debug}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, ifa.tx_valid}, 32'd0);
    check("arst_busy", {31'd0, ifa.busy}, 32'd0);
    check("arst_addr", {27'd0, ifa.read_direc_debug}, 32'd0);
    sb_a.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    run_dump(0, 161);

    run_dump(3, 161);
    run_dump(4, 211);

    // Narrow variant: 16-bit registers, 4 of them
    for (int r = 0; r < 4; r++) begin
      logic [7:0] lo;
      lo = r[7:0];
      sb_b.push_back(8'h12);
      sb_b.push_back(lo);
    end
    base = acc_b;
    @(posedge clk); #1;
    ifb.start = 1'b1; ifb.tx_ready = 1'b1;
    cyc = 0;
    guard = 0;
    while (guard == 0 && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      ifb.start = 1'b0;
      @(negedge clk);
      if (ifb.done) guard = 1;
    end
    check("b_done_latency", cyc, 32'd13);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("b_byte_count", acc_b - base, 32'd8);
    check("sb_b_empty", sb_b.size(), 32'd0);
    check("b_idle", {31'd0, ifb.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
